instr_encoder_loader: RTL and testbench

- Encoder for our MIPS-subset instruction set: the write side of the op/fn decode done by the control unit.
- Accepts symbolic instruction requests (mnemonic code plus register, immediate and target fields) over a valid/ready handshake.
- Encodes each request into a 32-bit MIPS instruction word, buffers it in a small FIFO, and writes it into instruction memory at sequential addresses over a req/ack handshake.
- Used by the boot/self-test path and the benches to load programs.

---
 rtl/instr_encoder_loader_if.sv | 47 ++++
 rtl/instr_encoder_loader.sv | 276 +++++++++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory bus of the instruction encoder/loader.
// Latency: none, plain signal bundle.
// Backpressure: in_valid/in_ready for requests, imem_wr_req/imem_wr_ack for memory writes.
//
// Ports (slave = encoder view):
//   in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target  -> request from host
//   in_ready                                                   <- request accepted
//   start, err_clr                                             -> control strobes
//   imem_wr_req, imem_addr, imem_wdata                         <- memory write
//   imem_wr_ack                                                -> memory write done
//   words_written, err_illegal, err_wrap, busy                 <- status
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_mnem;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              start;
    logic              imem_wr_req;
    logic              imem_wr_ack;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_written;
    logic              err_illegal;
    logic              err_wrap;
    logic              err_clr;
    logic              busy;

    modport master (
        output in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
        output start, err_clr, imem_wr_ack,
        input  in_ready, imem_wr_req, imem_addr, imem_wdata,
        input  words_written, err_illegal, err_wrap, busy
    );

    modport slave (
        input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
        input  start, err_clr, imem_wr_ack,
        output in_ready, imem_wr_req, imem_addr, imem_wdata,
        output words_written, err_illegal, err_wrap, busy
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encoded-word FIFO used by the loader: head and the entry behind it are both visible.
// Latency: push visible at head one cycle after the push edge.
// Backpressure: full_o blocks pushes unless a pop happens on the same edge.
//
// Ports: clk, rst_n; push_i/push_dat_i write side; pop_i read side;
//        head_dat_o, next_dat_o, full_o, empty_o, count_o status.
module iel_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             push_dat_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_dat_o,
    output logic [W-1:0]             next_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   count_q;
    logic [AW-1:0] rd_nxt;
    logic          pop_ok;
    logic          push_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign pop_ok  = pop_i && !empty_o;
    // A push into a full FIFO is fine when the head leaves on the same edge.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rd_nxt  = rd_ptr_q + AW'(1);

    assign head_dat_o = mem_q[rd_ptr_q];
    assign next_dat_o = mem_q[rd_nxt];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_nxt;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// Encodes symbolic MIPS-subset requests into 32-bit words and writes them to imem sequentially.
// Latency: accept edge to first imem_wr_req high is 1 cycle; back-to-back writes while words remain.
// Backpressure: in_ready = FIFO not full; the memory side stalls on imem_wr_ack.
//
// Ports: clk, rst_n (async active-low); bus (slave modport) carries the request
//        handshake, imem write handshake, start/err_clr strobes and status outputs.
module instr_encoder_loader #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_encoder_loader_if.slave bus
);
    localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    logic [31:0] enc_word;
    logic        enc_legal;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;

    assign rs  = bus.in_rs;
    assign rt  = bus.in_rt;
    assign rd  = bus.in_rd;
    assign imm = bus.in_imm;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (bus.in_mnem)
            5'd0:    enc_word = r_word(rs, rt, rd, 6'b000100);   // SLLV
            5'd1:    enc_word = r_word(rs, rt, rd, 6'b000110);   // SRLV
            5'd2:    enc_word = r_word(rs, rt, rd, 6'b000111);   // SRAV
            5'd3:    enc_word = r_word(rs, 5'd0, 5'd0, 6'b001000); // JR: only rs is meaningful
            5'd4:    enc_word = r_word(rs, rt, rd, 6'b100000);   // ADD
            5'd5:    enc_word = r_word(rs, rt, rd, 6'b100001);   // ADDU
            5'd6:    enc_word = r_word(rs, rt, rd, 6'b100010);   // SUB
            5'd7:    enc_word = r_word(rs, rt, rd, 6'b100011);   // SUBU
            5'd8:    enc_word = r_word(rs, rt, rd, 6'b100100);   // AND
            5'd9:    enc_word = r_word(rs, rt, rd, 6'b100101);   // OR
            5'd10:   enc_word = r_word(rs, rt, rd, 6'b100110);   // XOR
            5'd11:   enc_word = r_word(rs, rt, rd, 6'b100111);   // NOR
            5'd12:   enc_word = {6'b000010, bus.in_target};      // J
            5'd13:   enc_word = i_word(6'b000100, rs, rt, imm);  // BEQ
            5'd14:   enc_word = i_word(6'b000101, rs, rt, imm);  // BNE
            5'd15:   enc_word = i_word(6'b000110, rs, 5'd0, imm); // BLEZ: rt field is fixed zero
            5'd16:   enc_word = i_word(6'b000111, rs, 5'd0, imm); // BGTZ: rt field is fixed zero
            5'd17:   enc_word = i_word(6'b001000, rs, rt, imm);  // ADDI
            5'd18:   enc_word = i_word(6'b001001, rs, rt, imm);  // ADDIU
            5'd19:   enc_word = i_word(6'b001100, rs, rt, imm);  // ANDI
            5'd20:   enc_word = i_word(6'b001101, rs, rt, imm);  // ORI
            5'd21:   enc_word = i_word(6'b001110, rs, rt, imm);  // XORI
            5'd22:   enc_word = i_word(6'b100011, rs, rt, imm);  // LW
            5'd23:   enc_word = i_word(6'b101011, rs, rt, imm);  // SW
            default: enc_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [31:0]   fifo_head;
    logic [31:0]   fifo_next;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          accept;
    logic          push;
    logic          ack_hit;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              err_ill_q, err_ill_d;
    logic              err_wrap_q, err_wrap_d;
    logic              busy;
    logic              start_ok;
    logic              wrap_evt;

    // Held low while in reset so the host never sees a spurious accept.
    assign bus.in_ready = rst_n && !fifo_full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && enc_legal;
    assign ack_hit      = (state_q == S_REQ) && bus.imem_wr_ack;

    iel_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (enc_word),
        .pop_i      (ack_hit),
        .head_dat_o (fifo_head),
        .next_dat_o (fifo_next),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // ------------------------------------------------------------------
    // Writer FSM
    // ------------------------------------------------------------------
    assign busy     = !fifo_empty || (state_q == S_REQ);
    assign start_ok = bus.start && !busy && !bus.in_valid;
    assign wrap_evt = ack_hit && (addr_q == '1);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        words_d    = words_q;
        // A new error event on the same edge as err_clr leaves the flag set.
        err_ill_d  = (err_ill_q && !bus.err_clr) || (accept && !enc_legal);
        err_wrap_d = (err_wrap_q && !bus.err_clr) || wrap_evt;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    wdata_d = fifo_head;
                end else if (start_ok) begin
                    addr_d  = BASE;
                    words_d = '0;
                end
            end
            S_REQ: begin
                if (ack_hit) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (words_q != WORDS_MAX) begin
                        words_d = words_q + (ADDR_W+1)'(1);
                    end
                    // After this pop the new head is either the entry behind the
                    // current one or, if that slot was empty, the word pushed now.
                    if (fifo_count > CW'(1)) begin
                        wdata_d = fifo_next;
                    end else if (push) begin
                        wdata_d = enc_word;
                    end else begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            addr_q     <= BASE;
            wdata_q    <= '0;
            words_q    <= '0;
            err_ill_q  <= 1'b0;
            err_wrap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            words_q    <= words_d;
            err_ill_q  <= err_ill_d;
            err_wrap_q <= err_wrap_d;
        end
    end

    assign bus.imem_wr_req   = req_q;
    assign bus.imem_addr     = addr_q;
    assign bus.imem_wdata    = wdata_q;
    assign bus.words_written = words_q;
    assign bus.err_illegal   = err_ill_q;
    assign bus.err_wrap      = err_wrap_q;
    assign bus.busy          = busy;
endmodule

// File: tb/tb_instr_encoder_loader.sv
`timescale 1ns/1ps
module tb_instr_encoder_loader;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) intf ();

    instr_encoder_loader #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (4),
        .BASE_ADDR  (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: field values placed by plain arithmetic.
    int r_fn [12] = '{4, 6, 7, 8, 32, 33, 34, 35, 36, 37, 38, 39};
    int i_op [11] = '{4, 5, 6, 7, 8, 9, 12, 13, 14, 35, 43};

    function automatic longint unsigned model_word(int m, int rs, int rt, int rd, int imm, int tgt);
        longint unsigned w;
        if (m < 12) begin
            if (m == 3) begin rt = 0; rd = 0; end
            w = r_fn[m] + rd * 2048 + rt * 65536 + longint'(rs) * 2097152;
        end else if (m == 12) begin
            w = 2 * 67108864 + longint'(tgt);
        end else begin
            if (m == 15 || m == 16) rt = 0;
            w = longint'(i_op[m-13]) * 67108864 + longint'(rs) * 2097152 + rt * 65536 + imm;
        end
        return w;
    endfunction

    logic [31:0]       exp_q [$];
    logic [ADDR_W-1:0] exp_addr;
    int                exp_words;

    // Memory responder
    bit                ack_en  = 1'b0;
    bit                rand_dly = 1'b0;
    int                ack_dly = 1;
    logic [ADDR_W-1:0] log_a [$];
    logic [31:0]       log_d [$];

    initial begin
        int wcnt = 0;
        intf.imem_wr_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && intf.imem_wr_req === 1'b1 && wcnt >= ack_dly) begin
                intf.imem_wr_ack = 1'b1;
                log_a.push_back(intf.imem_addr);
                log_d.push_back(intf.imem_wdata);
                wcnt = 0;
                if (rand_dly) ack_dly = $urandom_range(0, 2);
            end else begin
                intf.imem_wr_ack = 1'b0;
                wcnt = (intf.imem_wr_req === 1'b1) ? wcnt + 1 : 0;
            end
        end
    end

    task automatic send(input int m, input int rs, input int rt, input int rd,
                        input int imm, input int tgt);
        int t = 0;
        @(negedge clk);
        intf.in_mnem   = 5'(m);
        intf.in_rs     = 5'(rs);
        intf.in_rt     = 5'(rt);
        intf.in_rd     = 5'(rd);
        intf.in_imm    = 16'(imm);
        intf.in_target = 26'(tgt);
        intf.in_valid  = 1'b1;
        while (intf.in_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 500) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready never rose for mnem %0d", m);
            intf.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 intf.in_valid = 1'b0;
            if (m < 24) exp_q.push_back(32'(model_word(m, rs, rt, rd, imm, tgt)));
        end
    endtask

    task automatic send_rand();
        send($urandom_range(0, 23), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 67108863));
    endtask

    task automatic wait_idle(output bit ok);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (intf.busy === 1'b0) break;
        end
        ok = (intf.busy === 1'b0);
    endtask

    task automatic do_start();
        @(negedge clk);
        intf.start = 1'b1;
        @(negedge clk);
        intf.start = 1'b0;
        exp_addr  = '0;
        exp_words = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        intf.in_valid = 0; intf.in_mnem = 0; intf.in_rs = 0; intf.in_rt = 0; intf.in_rd = 0;
        intf.in_imm = 0; intf.in_target = 0; intf.start = 0; intf.err_clr = 0;
        #2;
        n_checks++; if (intf.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", intf.in_ready); end
        n_checks++; if (intf.imem_wr_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", intf.imem_wr_req); end
        n_checks++; if (intf.imem_addr !== 8'h00) begin n_fail++; $display("FAIL rst_addr: got %h want 00", intf.imem_addr); end
        n_checks++; if (intf.imem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", intf.imem_wdata); end
        n_checks++; if (intf.words_written !== 9'd0) begin n_fail++; $display("FAIL rst_words: got %0d want 0", intf.words_written); end
        n_checks++; if (intf.err_illegal !== 1'b0 || intf.err_wrap !== 1'b0) begin n_fail++; $display("FAIL rst_errs: got %b%b want 00", intf.err_illegal, intf.err_wrap); end
        n_checks++; if (intf.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", intf.busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_addr = '0; exp_words = 0;
        @(negedge clk);
        n_checks++; if (intf.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b want 1", intf.in_ready); end
    endtask

    task automatic test_directed();
        bit ok;
        logic [31:0] lit [5];
        lit[0] = 32'h00221820; lit[1] = 32'h8FA80004; lit[2] = 32'h08000010;
        lit[3] = 32'h1880FFFE; lit[4] = 32'h03E00008;
        ack_en = 1'b1; rand_dly = 1'b0; ack_dly = 1;
        send(4, 1, 2, 3, 0, 0);
        @(negedge clk);
        n_checks++; if (intf.imem_wr_req !== 1'b0) begin n_fail++; $display("FAIL latency_early: req %b want 0", intf.imem_wr_req); end
        @(negedge clk);
        n_checks++; if (intf.imem_wr_req !== 1'b1 || intf.imem_wdata !== lit[0]) begin
            n_fail++; $display("FAIL latency_req: req %b data %h want 1 %h", intf.imem_wr_req, intf.imem_wdata, lit[0]); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL add_idle: busy stuck %b want 0", intf.busy); end
        n_checks++; if (intf.words_written !== 9'd1) begin n_fail++; $display("FAIL add_words: got %0d want 1", intf.words_written); end
        send(22, 29, 8, 0, 16'h0004, 0);
        send(12, 0, 0, 0, 0, 26'h10);
        send(15, 4, 7, 0, 16'hFFFE, 0);
        send(3, 31, 5, 9, 0, 0);
        wait_idle(ok);
        n_checks++; if (log_d.size() != 5) begin n_fail++; $display("FAIL directed_count: got %0d want 5", log_d.size()); end
        for (int i = 0; i < 5 && log_d.size() > 0; i++) begin
            logic [ADDR_W-1:0] a;
            logic [31:0] d;
            a = log_a.pop_front(); d = log_d.pop_front();
            n_checks++;
            if (a !== 8'(i) || d !== lit[i]) begin
                n_fail++; $display("FAIL directed_word%0d: got %h@%h want %h@%h", i, d, a, lit[i], 8'(i));
            end
        end
        exp_q.delete(); log_a.delete(); log_d.delete();
        exp_addr = 8'd5; exp_words = 5;
    endtask

    task automatic test_random();
        bit ok;
        rand_dly = 1'b1;
        for (int i = 0; i < 40; i++) send_rand();
        wait_idle(ok);
        n_checks++; if (!ok || log_d.size() != exp_q.size()) begin
            n_fail++; $display("FAIL random_count: got %0d writes want %0d", log_d.size(), exp_q.size()); end
        while (log_d.size() > 0 && exp_q.size() > 0) begin
            logic [ADDR_W-1:0] a;
            logic [31:0] d, e;
            a = log_a.pop_front(); d = log_d.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (d !== e || a !== exp_addr) begin
                n_fail++; $display("FAIL random_word: got %h@%h want %h@%h", d, a, e, exp_addr);
            end
            exp_addr++; if (exp_words < 256) exp_words++;
        end
        n_checks++; if (intf.words_written !== 9'(exp_words)) begin
            n_fail++; $display("FAIL random_words: got %0d want %0d", intf.words_written, exp_words); end
        exp_q.delete(); log_a.delete(); log_d.delete();
        rand_dly = 1'b0; ack_dly = 1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit stable = 1'b1;
        logic [ADDR_W-1:0] a0;
        logic [31:0] d0;
        do_start();
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) send_rand();
        @(negedge clk);
        n_checks++; if (intf.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", intf.in_ready); end
        n_checks++; if (intf.imem_wr_req !== 1'b1) begin n_fail++; $display("FAIL held_req: got %b want 1", intf.imem_wr_req); end
        a0 = intf.imem_addr; d0 = intf.imem_wdata;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (intf.imem_wr_req !== 1'b1 || intf.imem_addr !== a0 || intf.imem_wdata !== d0) stable = 1'b0;
        end
        n_checks++; if (!stable || d0 !== exp_q[0] || a0 !== 8'h00) begin
            n_fail++; $display("FAIL held_stable: got %h@%h stable=%b want %h@00", d0, a0, stable, exp_q[0]); end
        fork
            begin repeat (2) @(negedge clk); ack_dly = 0; ack_en = 1'b1; end
            send_rand();
        join
        wait_idle(ok);
        n_checks++; if (!ok || log_d.size() != 5) begin n_fail++; $display("FAIL b2b_count: got %0d want 5", log_d.size()); end
        while (log_d.size() > 0 && exp_q.size() > 0) begin
            logic [ADDR_W-1:0] a;
            logic [31:0] d, e;
            a = log_a.pop_front(); d = log_d.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (d !== e || a !== exp_addr) begin
                n_fail++; $display("FAIL b2b_word: got %h@%h want %h@%h", d, a, e, exp_addr);
            end
            exp_addr++; if (exp_words < 256) exp_words++;
        end
        exp_q.delete(); log_a.delete(); log_d.delete();
    endtask

    task automatic test_illegal_start();
        bit ok;
        bit saw_req = 1'b0;
        send(27, 1, 2, 3, 4, 5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (intf.imem_wr_req !== 1'b0) saw_req = 1'b1;
        end
        n_checks++; if (saw_req || intf.busy !== 1'b0 || log_d.size() != 0) begin
            n_fail++; $display("FAIL illegal_noreq: req_seen=%b busy=%b writes=%0d want 0 0 0", saw_req, intf.busy, log_d.size()); end
        n_checks++; if (intf.err_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b want 1", intf.err_illegal); end
        @(negedge clk); intf.err_clr = 1'b1;
        @(negedge clk); intf.err_clr = 1'b0;
        n_checks++; if (intf.err_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_clr: got %b want 0", intf.err_illegal); end
        // New illegal request on the same edge as err_clr.
        @(negedge clk);
        intf.in_mnem = 5'd30; intf.in_valid = 1'b1; intf.err_clr = 1'b1;
        @(posedge clk);
        #1 intf.in_valid = 1'b0; intf.err_clr = 1'b0;
        @(negedge clk);
        n_checks++; if (intf.err_illegal !== 1'b1) begin n_fail++; $display("FAIL set_wins: got %b want 1", intf.err_illegal); end
        // start while busy is ignored.
        ack_en = 1'b0;
        send(9, 3, 4, 5, 0, 0);
        @(negedge clk); intf.start = 1'b1;
        @(negedge clk); intf.start = 1'b0;
        ack_en = 1'b1;
        wait_idle(ok);
        n_checks++; if (log_a.size() != 1 || log_a[0] !== exp_addr || log_d[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL start_busy: got %0d writes first@%h want 1@%h", log_a.size(), (log_a.size() > 0) ? log_a[0] : 8'hxx, exp_addr); end
        exp_q.delete(); log_a.delete(); log_d.delete();
        // start while idle restarts at BASE_ADDR.
        do_start();
        n_checks++; if (intf.words_written !== 9'd0 || intf.imem_addr !== 8'h00) begin
            n_fail++; $display("FAIL start_idle: got %0d@%h want 0@00", intf.words_written, intf.imem_addr); end
        send_rand();
        wait_idle(ok);
        n_checks++; if (log_a.size() != 1 || log_a[0] !== 8'h00 || log_d[0] !== exp_q[0] || intf.words_written !== 9'd1) begin
            n_fail++; $display("FAIL start_write: got %0d writes words=%0d want 1 at 00 words=1", log_a.size(), intf.words_written); end
        exp_q.delete(); log_a.delete(); log_d.delete();
        exp_addr = 8'h01; exp_words = 1;
        @(negedge clk); intf.err_clr = 1'b1;
        @(negedge clk); intf.err_clr = 1'b0;
    endtask

    task automatic test_wrap();
        bit ok;
        int bad = 0;
        do_start();
        ack_dly = 0;
        for (int i = 0; i < 255; i++) send_rand();
        wait_idle(ok);
        while (log_d.size() > 0 && exp_q.size() > 0) begin
            logic [ADDR_W-1:0] a;
            logic [31:0] d, e;
            a = log_a.pop_front(); d = log_d.pop_front(); e = exp_q.pop_front();
            if (d !== e || a !== exp_addr) bad++;
            exp_addr++; if (exp_words < 256) exp_words++;
        end
        n_checks++; if (!ok || bad != 0 || exp_words != 255) begin
            n_fail++; $display("FAIL preload: bad=%0d writes=%0d want 0 bad 255 writes", bad, exp_words); end
        n_checks++; if (intf.imem_addr !== 8'hFF || intf.words_written !== 9'd255 || intf.err_wrap !== 1'b0) begin
            n_fail++; $display("FAIL preload_state: got %h/%0d/%b want ff/255/0", intf.imem_addr, intf.words_written, intf.err_wrap); end
        send_rand();
        wait_idle(ok);
        n_checks++; if (log_a.size() != 1 || log_a[0] !== 8'hFF || log_d[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL wrap_write: got %0d writes want 1 at ff", log_a.size()); end
        n_checks++; if (intf.imem_addr !== 8'h00 || intf.err_wrap !== 1'b1 || intf.words_written !== 9'd256) begin
            n_fail++; $display("FAIL wrap_state: got %h/%b/%0d want 00/1/256", intf.imem_addr, intf.err_wrap, intf.words_written); end
        exp_q.delete(); log_a.delete(); log_d.delete();
        send_rand();
        wait_idle(ok);
        n_checks++; if (intf.words_written !== 9'd256 || intf.imem_addr !== 8'h01 || log_a.size() != 1 || log_a[0] !== 8'h00) begin
            n_fail++; $display("FAIL words_sat: got %0d@%h want 256@01", intf.words_written, intf.imem_addr); end
        exp_q.delete(); log_a.delete(); log_d.delete();
        @(negedge clk); intf.err_clr = 1'b1;
        @(negedge clk); intf.err_clr = 1'b0;
        n_checks++; if (intf.err_wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_clr: got %b want 0", intf.err_wrap); end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        ack_en = 1'b0;
        send_rand();
        send_rand();
        while (intf.imem_wr_req !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        n_checks++; if (intf.imem_wr_req !== 1'b1) begin n_fail++; $display("FAIL mid_req_rise: got %b want 1", intf.imem_wr_req); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (intf.imem_wr_req !== 1'b0 || intf.busy !== 1'b0 || intf.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_ctrl: req/busy/rdy %b%b%b want 000", intf.imem_wr_req, intf.busy, intf.in_ready); end
        n_checks++; if (intf.imem_addr !== 8'h00 || intf.imem_wdata !== 32'h0 || intf.words_written !== 9'd0) begin
            n_fail++; $display("FAIL mid_rst_regs: got %h/%h/%0d want 00/0/0", intf.imem_addr, intf.imem_wdata, intf.words_written); end
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        ack_en = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (log_d.size() != 0 || intf.busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_discard: got %0d writes busy=%b want 0 0", log_d.size(), intf.busy); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_illegal_start();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
